// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus the valid/ready output stream of fifo_stream_reader.
// The master side is the reader; the slave side is the FIFO and the downstream sink.
interface fifo_stream_reader_if #(
  parameter int unsigned Width    = 8,
  parameter int unsigned CntWidth = 3
);
  logic                fifo_empty;
  logic [Width-1:0]    fifo_rdata;
  logic                fifo_rd_en;
  logic                m_valid;
  logic                m_ready;
  logic [Width-1:0]    m_data;
  logic                m_last;
  logic [CntWidth-1:0] beat_cnt;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last, beat_cnt
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last, beat_cnt
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream with burst framing. A 3-entry skid
// buffer absorbs the FIFO's 1-cycle read latency so the stream sustains one word per clock.
module fifo_stream_reader #(
  parameter int unsigned Width    = 8,
  parameter int unsigned BurstLen = 4,
  parameter int unsigned CntWidth = $clog2(BurstLen) + 1
) (
  input  logic                 clk_i,
  input  logic                 res_n_i,
  input  logic                 en_i,
  output logic                 busy_o,
  fifo_stream_reader_if.master bus_io
);

  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(BurstLen - 1);

  logic [1:0]          occ_q, occ_d;
  logic [1:0]          head_q, head_d;
  logic [1:0]          tail_q, tail_d;
  logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;
  logic                inflight_q;
  logic                run_q;
  logic [Width-1:0]    buf_q [3];

  logic rd_en;
  logic push;
  logic pop;
  logic valid;
  logic last;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // run_q keeps the pop request low throughout reset and clears with it asynchronously.
  assign rd_en = run_q & en_i & ~bus_io.fifo_empty &
                 (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
  assign push  = inflight_q;
  assign valid = (occ_q != 2'd0);
  assign pop   = valid & bus_io.m_ready;
  assign last  = valid & (beat_cnt_q == LastBeat);

  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    beat_cnt_d = beat_cnt_q;
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d     = ptr_inc(head_q);
      beat_cnt_d = last ? '0 : beat_cnt_q + CntWidth'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      occ_q      <= 2'd0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= rd_en;
      run_q      <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been captured.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_q[tail_q] <= bus_io.fifo_rdata;
    end
  end

  assign bus_io.fifo_rd_en = rd_en;
  assign bus_io.m_valid    = valid;
  assign bus_io.m_data     = valid ? buf_q[head_q] : '0;
  assign bus_io.m_last     = last;
  assign bus_io.beat_cnt   = beat_cnt_q;
  assign busy_o            = inflight_q | valid;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: behavioural FIFO, scoreboard of written words,
// a latency table, and directed/random sequences for stall, empty, enable and reset cases.
module tb_fifo_stream_reader;
  localparam int unsigned Width    = 8;
  localparam int unsigned BurstLen = 4;
  localparam int unsigned CntWidth = $clog2(BurstLen) + 1;
  localparam int          Bl       = 4;
  localparam int          Depth    = 16;

  logic       clk = 1'b0;
  logic       res_n;
  logic       en;
  logic       busy;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] fifo_rdata = 8'h00;
  logic [7:0] fifo_q [$];
  int         fifo_cnt = 0;
  logic [7:0] wr_log [0:4095];
  int         wr_total = 0;
  int         pops_total = 0;
  int         underflow = 0;

  int         n_chk = 0;
  int         n_err = 0;
  int         rd_idx = 0;
  int         beats = 0;
  int         last_cnt = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    logic       rd_en;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [2:0] beat;
  } vec_t;
  vec_t tbl [8];

  fifo_stream_reader_if #(.Width(Width), .CntWidth(CntWidth)) bus ();

  fifo_stream_reader #(
    .Width   (Width),
    .BurstLen(BurstLen)
  ) dut (
    .clk_i  (clk),
    .res_n_i(res_n),
    .en_i   (en),
    .busy_o (busy),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  assign bus.fifo_empty = (fifo_cnt == 0);
  assign bus.fifo_rdata = fifo_rdata;

  // Synchronous FIFO: registered read data, write visible after the edge.
  always @(posedge clk) begin
    logic [7:0] w;
    if (bus.fifo_rd_en) begin
      if (fifo_q.size() == 0) begin
        underflow++;
      end else begin
        w = fifo_q.pop_front();
        fifo_rdata <= w;
        pops_total++;
      end
    end
    if (wr_en && fifo_q.size() < Depth) begin
      fifo_q.push_back(wr_data);
      wr_log[wr_total] = wr_data;
      wr_total++;
    end
    fifo_cnt <= fifo_q.size();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted beat is the next word popped from the FIFO; a reset discards
  // whatever had been popped but not delivered and restarts the burst count.
  task automatic monitor();
    logic [31:0] exp_d;
    if (!res_n) begin
      rd_idx     = pops_total;
      beats      = 0;
      prev_valid = 1'b0;
      return;
    end
    if (bus.fifo_rd_en) chk("rd_en_while_empty", 32'(bus.fifo_empty), 0);
    chk("beat_cnt", 32'(bus.beat_cnt), 32'(beats % Bl));
    chk("m_last", 32'(bus.m_last), 32'(bus.m_valid && (beats % Bl == Bl - 1)));
    if (prev_valid && !prev_ready) begin
      chk("stall_valid", 32'(bus.m_valid), 1);
      chk("stall_data", 32'(bus.m_data), 32'(prev_data));
    end
    if (bus.m_valid && bus.m_ready) begin
      exp_d = (rd_idx < wr_total) ? 32'(wr_log[rd_idx]) : 32'hDEAD_BEEF;
      chk("beat_data", 32'(bus.m_data), exp_d);
      if (bus.m_last) last_cnt++;
      rd_idx++;
      beats++;
    end
    prev_valid = bus.m_valid;
    prev_ready = bus.m_ready;
    prev_data  = bus.m_data;
  endtask

  // Inputs are driven at the negedge; the monitor samples 1 time unit later, before the posedge.
  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
  endtask

  initial begin
    int first_v;
    int last_v;
    int nv;
    int pulses;
    int l0;
    int p0;
    bit seen;

    res_n       = 1'b0;
    en          = 1'b0;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    bus.m_ready = 1'b0;
    @(negedge clk);

    // T1: reset with a non-empty FIFO and en=1
    write_words(8'hA0, 4);
    en = 1'b1;
    tick();
    tick();
    #1;
    chk("t1_rd_en", 32'(bus.fifo_rd_en), 0);
    chk("t1_valid", 32'(bus.m_valid), 0);
    chk("t1_beat_cnt", 32'(bus.beat_cnt), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_last", 32'(bus.m_last), 0);
    res_n       = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t1_drained", rd_idx, 4);

    // T2: full-rate stream with latency table
    en = 1'b0;
    write_words(8'h00, 16);
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 1'b1, 8'h00, 1'b0, 3'd0};
    tbl[3] = '{1'b1, 1'b1, 8'h01, 1'b0, 3'd1};
    tbl[4] = '{1'b1, 1'b1, 8'h02, 1'b0, 3'd2};
    tbl[5] = '{1'b1, 1'b1, 8'h03, 1'b1, 3'd3};
    tbl[6] = '{1'b1, 1'b1, 8'h04, 1'b0, 3'd0};
    tbl[7] = '{1'b1, 1'b1, 8'h05, 1'b0, 3'd1};
    l0      = last_cnt;
    first_v = -1;
    last_v  = -1;
    nv      = 0;
    en      = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (c < 8) begin
        chk($sformatf("t2_row%0d_rd_en", c), 32'(bus.fifo_rd_en), 32'(tbl[c].rd_en));
        chk($sformatf("t2_row%0d_valid", c), 32'(bus.m_valid), 32'(tbl[c].valid));
        if (tbl[c].valid) begin
          chk($sformatf("t2_row%0d_data", c), 32'(bus.m_data), 32'(tbl[c].data));
          chk($sformatf("t2_row%0d_last", c), 32'(bus.m_last), 32'(tbl[c].last));
          chk($sformatf("t2_row%0d_beat", c), 32'(bus.beat_cnt), 32'(tbl[c].beat));
        end
      end
      if (bus.m_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        nv++;
      end
      tick();
    end
    chk("t2_beats", nv, 16);
    chk("t2_contiguous", last_v - first_v + 1, 16);
    chk("t2_last_pulses", last_cnt - l0, 4);
    chk("t2_underflow", underflow, 0);

    // T3: backpressure with a full FIFO, then random ready
    en          = 1'b0;
    bus.m_ready = 1'b0;
    write_words(8'h00, 16);
    en     = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.fifo_rd_en) pulses++;
      tick();
    end
    chk("t3_pop_pulses", pulses, 3);
    chk("t3_held_valid", 32'(bus.m_valid), 1);
    chk("t3_held_data", 32'(bus.m_data), 32'h00);
    for (int i = 0; i < 400 && rd_idx < wr_total; i++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.m_ready = 1'b1;
    tick();
    chk("t3_all_delivered", rd_idx, wr_total);

    // T4: FIFO runs dry mid-burst
    l0 = last_cnt;
    write_words(8'h40, 5);
    for (int i = 0; i < 8; i++) tick();
    chk("t4_last_after5", last_cnt - l0, 1);
    chk("t4_beat_cnt_1", 32'(bus.beat_cnt), 1);
    chk("t4_paused", 32'(bus.m_valid), 0);
    write_words(8'h48, 3);
    for (int i = 0; i < 8; i++) tick();
    chk("t4_last_after8", last_cnt - l0, 2);
    chk("t4_beat_cnt_0", 32'(bus.beat_cnt), 0);
    chk("t4_delivered", rd_idx, wr_total);

    // T5: en dropped the cycle after a single pop
    en = 1'b0;
    write_words(8'h50, 6);
    p0 = pops_total;
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_one_pop", pops_total - p0, 1);
    chk("t5_busy_low", 32'(busy), 0);
    chk("t5_fifo_left", fifo_cnt, 5);
    chk("t5_delivered", rd_idx, wr_total - 5);

    // T6: asynchronous reset with occ=2 and a pop in flight
    bus.m_ready = 1'b0;
    en          = 1'b1;
    tick();
    tick();
    tick();
    #1;
    chk("t6_pre_valid", 32'(bus.m_valid), 1);
    chk("t6_pre_data", 32'(bus.m_data), 32'h51);
    chk("t6_pre_busy", 32'(busy), 1);
    #1;
    res_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.m_valid), 0);
    chk("t6_rst_data", 32'(bus.m_data), 0);
    chk("t6_rst_last", 32'(bus.m_last), 0);
    chk("t6_rst_beat", 32'(bus.beat_cnt), 0);
    chk("t6_rst_rd_en", 32'(bus.fifo_rd_en), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    tick();
    res_n       = 1'b1;
    bus.m_ready = 1'b1;
    seen        = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (bus.m_valid) begin
        seen = 1'b1;
        chk("t6_resume_data", 32'(bus.m_data), 32'h54);
        chk("t6_resume_beat", 32'(bus.beat_cnt), 0);
      end else begin
        tick();
      end
    end
    if (!seen) chk("t6_resume_timeout", 32'(seen), 1);
    for (int i = 0; i < 6; i++) tick();

    // T7: random soak
    for (int i = 0; i < 400; i++) begin
      en          = ($urandom_range(0, 3) != 0);
      bus.m_ready = ($urandom_range(0, 2) != 0);
      wr_en       = (fifo_cnt < Depth - 1) && ($urandom_range(0, 1) == 1);
      wr_data     = 8'($urandom);
      tick();
    end
    wr_en       = 1'b0;
    en          = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("t7_delivered", rd_idx, wr_total);
    chk("t7_busy_low", 32'(busy), 0);
    chk("final_underflow", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
